seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's 16-bit ALU. It keeps the same 4-bit function encoding and one-hot class flags. It adds a configurable data width, valid/ready handshakes on both sides, a multi-cycle restoring divider, variable shift amounts, an arithmetic right shift, and carry and divide-by-zero status. It sits between the operand-fetch stage and the result writeback stage. Results are held until writeback consumes them.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept an operation
- a, b  in  WIDTH  unsigned operands
- alu_fun  in  4  operation code
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_out  out  WIDTH  result
- arith_flag, logic_flag, cmp_flag, shift_flag  out  1 each  one-hot operation class of held result
- carry_flag  out  1  carry/borrow/overflow (arith only)
- div_zero  out  1  divide by zero occurred

## Operation
- Opcodes:
  - 0000 a+b
  - 0001 a−b
  - 0010 a*b (low WIDTH bits)
  - 0011 a/b (unsigned quotient)
  - 0100 AND
  - 0101 OR
  - 0110 NAND
  - 0111 NOR
  - 1000 XOR
  - 1001 XNOR
  - 1010 a==b ? 1 : 0
  - 1011 a>b ? 2 : 0
  - 1100 a<b ? 3 : 0
  - 1101 a >> b[SHW-1:0] (logical)
  - 1110 a << b[SHW-1:0]
  - 1111 a >>> b[SHW-1:0] (arithmetic, a[WIDTH-1] replicated)
- Flag classes:
  - arith_flag: 0000–0011
  - logic_flag: 0100–1001
  - cmp_flag: 1010–1100
  - shift_flag: 1101–1111
- carry_flag:
  - add: carry out of bit WIDTH-1
  - sub: borrow (a<b)
  - mul: upper WIDTH bits of the full product non-zero
  - all other ops: 0
- div_zero: set only for 0011 with b==0. In that case alu_out = all ones and carry_flag = 0.
- States:
  - IDLE:
    - in_ready=1.
    - Transfer on in_valid & in_ready. Operands and opcode are latched at this edge.
    - Non-divide op, or divide with b==0: result and flags registered, go to DONE.
    - Divide with b≠0: load dividend/divisor, clear partial remainder, counter=WIDTH, go to DIV.
  - DIV:
    - in_ready=0.
    - One restoring iteration per cycle, MSB first; counter decrements.
    - When counter reaches 0, register quotient with arith_flag=1, go to DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - alu_out and all flags held stable.
    - On out_ready, go to IDLE. The next operation is accepted no earlier than the following cycle.
- Outputs and flags change only on entry to DONE or on reset. They are stable from DONE entry until the out_ready transfer.
- in_valid while in_ready=0 is ignored. No operands are captured.
- Reset values:
  - State IDLE.
  - out_valid=0, in_ready=1 (first cycle after rst deasserts).
  - alu_out=0, all flags=0, divider counter/remainder=0.
- Reset mid-DIV or in DONE: the operation or result is discarded, and all outputs return to reset values on the next edge.

## Timing
- Accept edge defined as cycle 0.
- Non-divide ops and divide-by-zero: out_valid=1 in cycle 1.
- Divide with b≠0: out_valid=1 in cycle WIDTH+1 (WIDTH=16 → cycle 17).
- With out_ready held high, out_valid lasts exactly one cycle.
- Max throughput: non-divide, one op per 2 cycles; divide, one op per WIDTH+2 cycles.
- All outputs are registered. No combinational path from in_valid or out_ready to any output except through state.

## Test plan
1. WIDTH=16, reset held 2 cycles, then release.
   - in_ready=1, out_valid=0, alu_out=0, all flags 0.
2. Add, a=0xFFFF, b=0x0001, out_ready=1.
   - Next cycle: out_valid=1, alu_out=0x0000, carry_flag=1, arith_flag=1.
   - Then sub, a=0x0003, b=0x0005: alu_out=0xFFFE, carry_flag=1.
3. Divide, a=1000, b=7.
   - out_valid in cycle 17, alu_out=142, div_zero=0.
   - in_valid pulsed during DIV: ignored, in_ready=0.
   - Then divide with b=0: out_valid in cycle 1, alu_out=0xFFFF, div_zero=1.
4. Shifts with a=0x8010:
   - 1111, b=4: 0xF801.
   - 1101, b=4: 0x0801.
   - 1110, b=0x0013 (amount 3): 0x0080, shift_flag=1.
   - Compares a=5, b=9: 1010→0, 1011→0, 1100→3 with cmp_flag=1.
5. Backpressure: out_ready=0 for 5 cycles after an XOR a=0x00FF, b=0x0F0F.
   - alu_out=0x0FF0 held stable, out_valid=1, in_ready=0.
   - Raise out_ready: IDLE next cycle.
6. Assert rst in cycle 8 of a divide.
   - Next cycle: all outputs at reset values.
   - A new add issued after reset completes correctly with 1-cycle latency.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked, width-parametrised ALU with a restoring divider.
// Results and status flags are registered and held until the consumer takes them.
module seq_alu #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             arith_flag,
  output logic             logic_flag,
  output logic             cmp_flag,
  output logic             shift_flag,
  output logic             carry_flag,
  output logic             div_zero
);

  localparam int CNT_W = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               arith_q, arith_d;
  logic               logic_q, logic_d;
  logic               cmp_q, cmp_d;
  logic               shift_q, shift_d;
  logic               carry_q, carry_d;
  logic               dz_q, dz_d;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   op_res;
  logic               op_carry;
  logic               op_dz;

  assign shamt = b[SHW-1:0];

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    op_res   = '0;
    op_carry = 1'b0;
    op_dz    = 1'b0;
    case (alu_fun)
      4'b0000: begin op_res = sum_ext[WIDTH-1:0];  op_carry = sum_ext[WIDTH];  end
      4'b0001: begin op_res = diff_ext[WIDTH-1:0]; op_carry = diff_ext[WIDTH]; end
      4'b0010: begin op_res = prod[WIDTH-1:0]; op_carry = |prod[2*WIDTH-1:WIDTH]; end
      // Only the divide-by-zero case is resolved here; b!=0 goes to the divider.
      4'b0011: begin op_res = '1; op_dz = (b == '0); end
      4'b0100: op_res = a & b;
      4'b0101: op_res = a | b;
      4'b0110: op_res = ~(a & b);
      4'b0111: op_res = ~(a | b);
      4'b1000: op_res = a ^ b;
      4'b1001: op_res = ~(a ^ b);
      4'b1010: op_res = (a == b) ? WIDTH'(1) : '0;
      4'b1011: op_res = (a > b)  ? WIDTH'(2) : '0;
      4'b1100: op_res = (a < b)  ? WIDTH'(3) : '0;
      4'b1101: op_res = a >> shamt;
      4'b1110: op_res = a << shamt;
      4'b1111: op_res = $signed(a) >>> shamt;
      default: op_res = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt, dvd_nxt;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    q_bit   = ~rem_sub[WIDTH];
    rem_nxt = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nxt = {dvd_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    arith_d = arith_q;
    logic_d = logic_q;
    cmp_d   = cmp_q;
    shift_d = shift_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (alu_fun == 4'b0011 && b != '0) begin
            dvd_d   = a;
            dvs_d   = b;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_DIV;
          end else begin
            res_d   = op_res;
            carry_d = op_carry;
            dz_d    = op_dz;
            arith_d = (alu_fun <= 4'd3);
            logic_d = (alu_fun >= 4'd4)  && (alu_fun <= 4'd9);
            cmp_d   = (alu_fun >= 4'd10) && (alu_fun <= 4'd12);
            shift_d = (alu_fun >= 4'd13);
            state_d = S_DONE;
          end
        end
      end
      S_DIV: begin
        dvd_d = dvd_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q - 1'b1;
        // The final iteration registers its quotient directly so the result
        // lands WIDTH cycles after the non-divide latency.
        if (cnt_q == CNT_W'(1)) begin
          res_d   = dvd_nxt;
          arith_d = 1'b1;
          logic_d = 1'b0;
          cmp_d   = 1'b0;
          shift_d = 1'b0;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      arith_q <= 1'b0;
      logic_q <= 1'b0;
      cmp_q   <= 1'b0;
      shift_q <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      arith_q <= arith_d;
      logic_q <= logic_d;
      cmp_q   <= cmp_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign alu_out    = res_q;
  assign arith_flag = arith_q;
  assign logic_flag = logic_q;
  assign cmp_flag   = cmp_q;
  assign shift_flag = shift_q;
  assign carry_flag = carry_q;
  assign div_zero   = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=16: expected results are queued at issue
// and compared with result value, flags and latency when out_valid appears.
module tb_seq_alu;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic [5:0]   fl;   // {arith, logic, cmp, shift, carry, div_zero}
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_fun = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         arith_flag, logic_flag, cmp_flag, shift_flag, carry_flag, div_zero;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  cyc = 0;
  int unsigned  acc_cyc = 0;
  exp_t         sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_fun(alu_fun), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag), .carry_flag(carry_flag),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic c, z;
    c = 1'b0; z = 1'b0; e.res = '0;
    case (f)
      4'd0:  begin s = x + y; e.res = s[W-1:0]; c = s[W]; end
      4'd1:  begin e.res = x - y; c = (x < y); end
      4'd2:  begin p = x * y; e.res = p[W-1:0]; c = (p[2*W-1:W] != 0); end
      4'd3:  begin if (y == 0) begin e.res = 16'hFFFF; z = 1'b1; end else e.res = x / y; end
      4'd4:  e.res = x & y;
      4'd5:  e.res = x | y;
      4'd6:  e.res = ~(x & y);
      4'd7:  e.res = ~(x | y);
      4'd8:  e.res = x ^ y;
      4'd9:  e.res = ~(x ^ y);
      4'd10: e.res = (x == y) ? 16'd1 : 16'd0;
      4'd11: e.res = (x > y)  ? 16'd2 : 16'd0;
      4'd12: e.res = (x < y)  ? 16'd3 : 16'd0;
      4'd13: e.res = x >> y[3:0];
      4'd14: e.res = x << y[3:0];
      default: e.res = $signed(x) >>> y[3:0];
    endcase
    e.fl = {f <= 4'd3, (f >= 4'd4 && f <= 4'd9), (f >= 4'd10 && f <= 4'd12), f >= 4'd13, c, z};
    return e;
  endfunction

  function automatic logic [5:0] obs_fl();
    return {arith_flag, logic_flag, cmp_flag, shift_flag, carry_flag, div_zero};
  endfunction

  // Called at a negedge with in_ready high; returns at the sample point after the accept edge.
  task automatic issue(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; alu_fun = f; a = x; b = y;
    sb.push_back(model(f, x, y));
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int unsigned lat, output bit to);
    int unsigned n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    to  = (out_valid !== 1'b1);
    lat = cyc - acc_cyc + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (alu_out !== '0 || obs_fl() !== 6'b0) begin
      errors++; $display("FAIL reset_out: alu_out=%h flags=%b required 0000/000000", alu_out, obs_fl());
    end
  endtask

  task automatic test_ops(input string name, input logic [3:0] fs[], input logic [W-1:0] xs[],
                          input logic [W-1:0] ys[], input logic [W-1:0] lits[]);
    int unsigned lat; bit to; exp_t e;
    for (int i = 0; i < fs.size(); i++) begin
      issue(fs[i], xs[i], ys[i]);
      wait_out(lat, to);
      e = sb.pop_front();
      checks++;
      if (to) begin
        errors++; $display("FAIL %s_timeout[%0d]: out_valid=%b required 1", name, i, out_valid);
      end else begin
        checks++;
        if (alu_out !== e.res || alu_out !== lits[i]) begin
          errors++; $display("FAIL %s_res[%0d]: got %h required %h", name, i, alu_out, lits[i]);
        end
        checks++;
        if (obs_fl() !== e.fl) begin
          errors++; $display("FAIL %s_flags[%0d]: got %b required %b", name, i, obs_fl(), e.fl);
        end
        if (lat != 1) begin
          errors++; $display("FAIL %s_lat[%0d]: got %0d required 1", name, i, lat);
        end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL %s_release[%0d]: out_valid=%b in_ready=%b required 0/1", name, i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_div();
    int unsigned lat; bit to; exp_t e;
    issue(4'd3, 16'd1000, 16'd7);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL div_busy_ready: got %b required 0", in_ready);
    end
    in_valid = 1'b1; alu_fun = 4'd0; a = 16'd5; b = 16'd1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat, to);
    e = sb.pop_front();
    checks++;
    if (to || alu_out !== 16'd142 || alu_out !== e.res || obs_fl() !== 6'b100000) begin
      errors++; $display("FAIL div_res: got %0d flags=%b to=%b required 142 flags=100000", alu_out, obs_fl(), to);
    end
    checks++;
    if (lat != 17) begin
      errors++; $display("FAIL div_lat: got %0d required 17", lat);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL div_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    issue(4'd3, 16'd55, 16'd0);
    wait_out(lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 1 || alu_out !== 16'hFFFF || obs_fl() !== 6'b100001 || obs_fl() !== e.fl) begin
      errors++; $display("FAIL div_zero: got %h flags=%b lat=%0d required ffff flags=100001 lat=1", alu_out, obs_fl(), lat);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int unsigned lat; bit to; exp_t e;
    out_ready = 1'b0;
    issue(4'd8, 16'h00FF, 16'h0F0F);
    wait_out(lat, to);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 16'h0FF0 || alu_out !== e.res
          || obs_fl() !== e.fl) begin
        errors++; $display("FAIL bp_hold[%0d]: v=%b r=%b out=%h flags=%b required 1/0 0ff0 %b",
                           i, out_valid, in_ready, alu_out, obs_fl(), e.fl);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lat; bit to; exp_t e; logic [3:0] f; logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 5) == 0) y = '0;
      else if (f == 4'd3 && $urandom_range(0, 1) == 1) y = 16'($urandom_range(1, 300));
      issue(f, x, y);
      wait_out(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || alu_out !== e.res || obs_fl() !== e.fl
          || lat != ((f == 4'd3 && y != 0) ? 17 : 1)) begin
        errors++; $display("FAIL b2b[%0d] f=%h a=%h b=%h: got %h/%b lat=%0d required %h/%b",
                           i, f, x, y, alu_out, obs_fl(), lat, e.res, e.fl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_div();
    int unsigned lat; bit to; exp_t e;
    issue(4'd3, 16'd60000, 16'd3);
    while (cyc - acc_cyc + 1 < 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_out !== '0 || obs_fl() !== 6'b0) begin
      errors++; $display("FAIL rst_mid_div: r=%b v=%b out=%h flags=%b required 1/0 0000 000000",
                         in_ready, out_valid, alu_out, obs_fl());
    end
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_discard: out_valid=%b required 0", out_valid);
    end
    issue(4'd0, 16'd100, 16'd23);
    wait_out(lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 1 || alu_out !== 16'd123 || obs_fl() !== e.fl) begin
      errors++; $display("FAIL rst_then_add: got %0d flags=%b lat=%0d required 123 %b lat=1", alu_out, obs_fl(), lat, e.fl);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ops("arith", '{4'd0, 4'd1, 4'd2, 4'd2},
             '{16'hFFFF, 16'h0003, 16'h1234, 16'h0003},
             '{16'h0001, 16'h0005, 16'h0100, 16'h0004},
             '{16'h0000, 16'hFFFE, 16'h3400, 16'h000C});
    test_div();
    test_ops("shift_cmp", '{4'd15, 4'd13, 4'd14, 4'd10, 4'd11, 4'd12, 4'd6, 4'd9},
             '{16'h8010, 16'h8010, 16'h8010, 16'd5, 16'd5, 16'd5, 16'hF0F0, 16'hF0F0},
             '{16'h0004, 16'h0004, 16'h0013, 16'd9, 16'd9, 16'd9, 16'hFF00, 16'hFF00},
             '{16'hF801, 16'h0801, 16'h0080, 16'h0000, 16'h0000, 16'h0003, 16'h0FFF, 16'hF00F});
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
